puf_response_gen: RTL and testbench
===================================

// Module: puf_response_gen
// PURPOSE
//  Measurement/response stage downstream of the RO-PUF oscillator banks and their 16:1 select muxes.
//  Per start, sequences RESP_BITS challenges, drives the shared mux select, and counts the two
//  selected ring-oscillator outputs over a fixed clk window. Compares the counts into one
//  response bit per challenge and presents the packed response on a valid/ready handshake.
// PARAMETERS
//  CNT_W         16    edge-counter width; counters saturate at 2^CNT_W-1
//  WIN_CYCLES    1024  clk cycles per counting window (>=1)
//  SETTLE_CYCLES 8     clk cycles after a select change before counting (>=3, covers sync flush)
//  RESP_BITS     8     response bits per start
//  SEL_W         4     mux select width; 2^SEL_W oscillators per bank
// PORTS
//  clk         in   1          system clock
//  rst_n       in   1          reset, synchronous, ACTIVE-HIGH (1 = reset), sampled on clk rise
//  start       in   1          single-cycle request; accepted only in IDLE with resp_valid=0
//  challenge   in   SEL_W      base challenge, captured when start is accepted
//  ro_a        in   1          selected RO output, bank A (asynchronous to clk)
//  ro_b        in   1          selected RO output, bank B (asynchronous to clk)
//  ro_sel      out  SEL_W      select to both bank muxes
//  ro_en       out  1          oscillator enable; 1 in SETTLE and COUNT only
//  busy        out  1          1 in any state other than IDLE
//  resp        out  RESP_BITS  packed response, bit k = result of challenge k
//  resp_valid  out  1          resp stable and valid
//  resp_ready  in   1          consumer accepts resp when resp_valid & resp_ready
//  tie_flag    out  1          sticky per response: some challenge gave cnt_a == cnt_b
//  sat_flag    out  1          sticky per response: some counter saturated
// BEHAVIOUR
//  Reset (rst_n=1 at clk rise): state IDLE; ro_sel=0, ro_en=0, busy=0, resp=0, resp_valid=0,
//   tie_flag=0, sat_flag=0; counters, bit index and sync flops cleared. Reset wins over all inputs.
//  Input path: ro_a/ro_b each pass 2-FF synchronizer then rising-edge detector (3rd flop);
//   one detected edge = +1 on that channel's counter, at most one per clk.
//  FSM: IDLE -> SETTLE -> COUNT -> COMPARE -> (SETTLE | DONE); DONE -> IDLE on handshake.
//   IDLE: start & !resp_valid -> capture challenge, k=0, clear tie/sat/resp, go SETTLE.
//   SETTLE: ro_sel = (challenge + k) mod 2^SEL_W; counters held at 0; edges ignored;
//    SETTLE_CYCLES cycles, then COUNT.
//   COUNT: exactly WIN_CYCLES cycles; counters increment on detected edges; saturate, set sat_flag.
//   COMPARE (1 cycle): resp[k] = (cnt_a > cnt_b); equal -> resp[k]=0 and tie_flag=1;
//    k==RESP_BITS-1 -> DONE, else k++ and SETTLE.
//   DONE: resp_valid=1, resp/flags held stable; ro_en=0; on resp_valid&resp_ready -> resp_valid=0,
//    IDLE the next cycle. resp retains last value in IDLE until the next accepted start.
//  Latency: start accepted at edge 0 -> resp_valid high after edge RESP_BITS*(SETTLE_CYCLES+WIN_CYCLES+1).
//  start while busy or resp_valid=1: ignored, not queued. start and resp_ready in the same DONE
//   cycle: handshake completes, start ignored.
//  ro_sel changes only on SETTLE entry; wraps modulo 2^SEL_W (e.g. challenge 14, k=3 -> ro_sel 1).
//  Reset mid-measurement: abandons run, no partial resp_valid; outputs at reset values next cycle.
// TESTING  (WIN_CYCLES=16, SETTLE_CYCLES=4, RESP_BITS=8 unless stated)
//  1 Reset: hold rst_n=1 3 cycles mid-COUNT -> all outputs 0, busy=0, state IDLE next cycle.
//  2 ro_a period 2 clk, ro_b period 4 clk, challenge=0 -> resp=8'hFF, tie=0, sat=0,
//    resp_valid after exactly 8*(4+16+1)=168 cycles; ro_sel steps 0..7.
//  3 Model ro_a faster only when ro_sel odd, equal otherwise -> resp=8'hAA, tie_flag=1.
//  4 challenge=4'hE -> ro_sel sequence E,F,0,1,2,3,4,5; start pulsed while busy -> no effect.
//  5 CNT_W=3, ro_a period 2 (8 edges) -> cnt_a saturates at 7, sat_flag=1, resp bit still 1 vs slow ro_b.
//  6 Hold resp_ready=0 20 cycles in DONE, pulse start -> resp/valid stable, start ignored;
//    resp_ready=1 -> resp_valid=0 next cycle, new start then accepted.

Source files
------------

// File: rtl/puf_response_gen_if.sv
// Request/response bus of the RO-PUF response generator.
//   master: requester side (drives start/challenge/resp_ready)
//   slave : puf_response_gen side (drives busy/resp/resp_valid/flags)
// Signals:
//   start      single-cycle measurement request
//   challenge  base challenge, captured when start is accepted
//   busy       generator is not idle
//   resp       packed response, bit k = result of challenge k
//   resp_valid resp stable and valid
//   resp_ready consumer accepts resp on resp_valid & resp_ready
//   tie_flag   sticky: some challenge produced equal counts
//   sat_flag   sticky: some counter saturated
interface puf_response_gen_if #(
    parameter int SEL_W     = 4,
    parameter int RESP_BITS = 8
);
    logic                 start;
    logic [SEL_W-1:0]     challenge;
    logic                 busy;
    logic [RESP_BITS-1:0] resp;
    logic                 resp_valid;
    logic                 resp_ready;
    logic                 tie_flag;
    logic                 sat_flag;

    modport master (
        output start, challenge, resp_ready,
        input  busy, resp, resp_valid, tie_flag, sat_flag
    );

    modport slave (
        input  start, challenge, resp_ready,
        output busy, resp, resp_valid, tie_flag, sat_flag
    );
endinterface

// File: rtl/puf_response_gen.sv
// RO-PUF measurement/response stage.
// For each start, walks RESP_BITS challenges (challenge + k mod 2^SEL_W), lets the
// selected oscillators settle, counts rising edges of both banks over WIN_CYCLES clocks,
// and turns each comparison into one response bit. The packed response is offered on a
// valid/ready handshake.
// Ports:
//   clk      system clock
//   rst_n    synchronous reset, active HIGH despite the name
//   ro_a     selected oscillator, bank A (asynchronous)
//   ro_b     selected oscillator, bank B (asynchronous)
//   ro_sel   mux select to both banks
//   ro_en    oscillator enable, high in SETTLE and COUNT
//   bus      request/response bus (slave side)

// One oscillator channel: 2-FF synchronizer, edge-detect flop, saturating counter.
module puf_ro_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // sync[1:0] synchronize, sync[2] is the previous synchronized sample
    logic [2:0] sync;
    logic       rise;

    assign rise = sync[1] & ~sync[2];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync <= '0;
            cnt  <= '0;
        end else begin
            sync <= {sync[1:0], ro};
            if (clr)
                cnt <= '0;
            else if (en && rise && cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

module puf_response_gen #(
    parameter int CNT_W         = 16,
    parameter int WIN_CYCLES    = 1024,
    parameter int SETTLE_CYCLES = 8,
    parameter int RESP_BITS     = 8,
    parameter int SEL_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic [SEL_W-1:0] ro_sel,
    output logic             ro_en,
    puf_response_gen_if.slave bus
);
    localparam int TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int K_W     = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WIN_LD    = TMR_W'(WIN_CYCLES - 1);
    localparam logic [K_W-1:0]   K_LAST    = K_W'(RESP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t               state;
    logic [TMR_W-1:0]     tmr;
    logic [K_W-1:0]       k;
    logic                 busy;
    logic [RESP_BITS-1:0] resp;
    logic                 resp_valid;
    logic                 tie_flag;
    logic                 sat_flag;

    // channel 0 = bank A, channel 1 = bank B
    logic [1:0]            ro_in;
    logic [1:0][CNT_W-1:0] cnt;
    logic                  cnt_clr;
    logic                  cnt_en;

    assign ro_in   = {ro_b, ro_a};
    assign cnt_clr = (state == S_SETTLE);
    assign cnt_en  = (state == S_COUNT);

    for (genvar i = 0; i < 2; i++) begin : g_ch
        puf_ro_counter #(.CNT_W(CNT_W)) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .ro    (ro_in[i]),
            .clr   (cnt_clr),
            .en    (cnt_en),
            .cnt   (cnt[i])
        );
    end

    assign bus.busy       = busy;
    assign bus.resp       = resp;
    assign bus.resp_valid = resp_valid;
    assign bus.tie_flag   = tie_flag;
    assign bus.sat_flag   = sat_flag;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= S_IDLE;
            tmr        <= '0;
            k          <= '0;
            ro_sel     <= '0;
            ro_en      <= 1'b0;
            busy       <= 1'b0;
            resp       <= '0;
            resp_valid <= 1'b0;
            tie_flag   <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start && !resp_valid) begin
                        ro_sel   <= bus.challenge;
                        k        <= '0;
                        resp     <= '0;
                        tie_flag <= 1'b0;
                        sat_flag <= 1'b0;
                        tmr      <= SETTLE_LD;
                        ro_en    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (tmr == '0) begin
                        tmr   <= WIN_LD;
                        state <= S_COUNT;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_COUNT: begin
                    if (tmr == '0) begin
                        ro_en <= 1'b0;
                        state <= S_COMPARE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_COMPARE: begin
                    resp[k] <= (cnt[0] > cnt[1]);
                    if (cnt[0] == cnt[1])
                        tie_flag <= 1'b1;
                    if (cnt[0] == CNT_MAX || cnt[1] == CNT_MAX)
                        sat_flag <= 1'b1;
                    if (k == K_LAST) begin
                        resp_valid <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        k      <= k + K_W'(1);
                        // ro_sel always equals challenge + k, so stepping it wraps naturally
                        ro_sel <= ro_sel + SEL_W'(1);
                        tmr    <= SETTLE_LD;
                        ro_en  <= 1'b1;
                        state  <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_puf_response_gen.sv
module tb_puf_response_gen;
    logic       clk;
    logic       rst_n;
    logic       mode;
    logic [7:0] tc = 8'd0;
    logic       ro_a, ro_b;
    logic [3:0] ro_sel;
    logic       ro_en;
    logic [3:0] ro_sel3;
    logic       ro_en3;
    int         checks = 0;
    int         fails  = 0;

    puf_response_gen_if #(.SEL_W(4), .RESP_BITS(8)) pif ();
    puf_response_gen_if #(.SEL_W(4), .RESP_BITS(8)) pif3 ();

    puf_response_gen #(
        .CNT_W(16), .WIN_CYCLES(16), .SETTLE_CYCLES(4), .RESP_BITS(8), .SEL_W(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ro_a   (ro_a),
        .ro_b   (ro_b),
        .ro_sel (ro_sel),
        .ro_en  (ro_en),
        .bus    (pif)
    );

    // narrow counters: a period-2 oscillator (8 edges/window) saturates at 7
    puf_response_gen #(
        .CNT_W(3), .WIN_CYCLES(16), .SETTLE_CYCLES(4), .RESP_BITS(8), .SEL_W(4)
    ) dut3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .ro_a   (tc[0]),
        .ro_b   (tc[1]),
        .ro_sel (ro_sel3),
        .ro_en  (ro_en3),
        .bus    (pif3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // tc[0]: period 2 clk, tc[1]: period 4 clk
    always @(negedge clk) tc <= tc + 8'd1;

    // mode 1: bank A fast only on odd selects, identical to bank B otherwise
    always_comb begin
        ro_a = tc[0];
        if (mode && !ro_sel[0]) ro_a = tc[1];
        ro_b = tc[1];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full run from start; checks ro_sel/ro_en per challenge and exact latency.
    task automatic run_seq(input logic [3:0] ch, input bit pulse);
        pif.challenge = ch;
        pif.start     = 1'b1;
        cyc(1);
        pif.start     = 1'b0;
        chk("busy_run", 32'(pif.busy), 32'd1);
        for (int k = 0; k < 8; k++) begin
            chk("ro_sel", 32'(ro_sel), 32'(4'(ch + 4'(k))));
            chk("ro_en_settle", 32'(ro_en), 32'd1);
            if (pulse && k == 1) begin
                pif.challenge = ch + 4'd8;
                pif.start     = 1'b1;
                cyc(1);
                pif.start     = 1'b0;
                cyc(19);
            end else begin
                cyc(20);
            end
            chk("ro_en_cmp", 32'(ro_en), 32'd0);
            chk("valid_early", 32'(pif.resp_valid), 32'd0);
            cyc(1);
        end
        chk("valid_168", 32'(pif.resp_valid), 32'd1);
        chk("busy_done", 32'(pif.busy), 32'd1);
    endtask

    task automatic ack();
        pif.resp_ready = 1'b1;
        cyc(1);
        pif.resp_ready = 1'b0;
        chk("ack_valid", 32'(pif.resp_valid), 32'd0);
        chk("ack_busy", 32'(pif.busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        mode  = 1'b0;
        pif.start = 1'b0;  pif.challenge = 4'd0;  pif.resp_ready = 1'b0;
        pif3.start = 1'b0; pif3.challenge = 4'd0; pif3.resp_ready = 1'b0;
        cyc(2);
        chk("rst_sel", 32'(ro_sel), 32'd0);
        chk("rst_en", 32'(ro_en), 32'd0);
        chk("rst_busy", 32'(pif.busy), 32'd0);
        chk("rst_resp", 32'(pif.resp), 32'd0);
        chk("rst_valid", 32'(pif.resp_valid), 32'd0);
        chk("rst_flags", 32'({pif.tie_flag, pif.sat_flag}), 32'd0);
        chk("rst3", 32'({ro_sel3, ro_en3, pif3.busy, pif3.resp_valid}), 32'd0);
        rst_n = 1'b0;
        cyc(1);

        // period 2 vs period 4 from challenge 0: all ones, no flags
        run_seq(4'h0, 1'b0);
        chk("t2_resp", 32'(pif.resp), 32'hFF);
        chk("t2_tie", 32'(pif.tie_flag), 32'd0);
        chk("t2_sat", 32'(pif.sat_flag), 32'd0);
        ack();

        // wrap from 0xE, start pulsed mid-run must not disturb anything
        run_seq(4'hE, 1'b1);
        chk("t4_resp", 32'(pif.resp), 32'hFF);

        // hold off the consumer in DONE; start must be ignored
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                pif.challenge = 4'h3;
                pif.start     = 1'b1;
            end else begin
                pif.start = 1'b0;
            end
            cyc(1);
        end
        pif.start = 1'b0;
        chk("t6_valid", 32'(pif.resp_valid), 32'd1);
        chk("t6_resp", 32'(pif.resp), 32'hFF);
        chk("t6_sel", 32'(ro_sel), 32'h5);
        chk("t6_en", 32'(ro_en), 32'd0);
        // handshake and start in the same cycle: handshake wins
        pif.resp_ready = 1'b1;
        pif.start      = 1'b1;
        cyc(1);
        pif.resp_ready = 1'b0;
        pif.start      = 1'b0;
        chk("t6_hs_valid", 32'(pif.resp_valid), 32'd0);
        chk("t6_hs_busy", 32'(pif.busy), 32'd0);
        chk("t6_hs_sel", 32'(ro_sel), 32'h5);
        chk("t6_hold_resp", 32'(pif.resp), 32'hFF);
        // next start is accepted
        mode = 1'b1;
        pif.challenge = 4'h1;
        pif.start     = 1'b1;
        cyc(1);
        pif.start = 1'b0;
        chk("t6_new_busy", 32'(pif.busy), 32'd1);
        chk("t6_new_sel", 32'(ro_sel), 32'h1);
        chk("t6_new_resp", 32'(pif.resp), 32'h0);

        // selects 1,2,3 done (bits 1,0,1), select 4 counting; then reset
        cyc(73);
        chk("t1_pre_resp", 32'(pif.resp), 32'h05);
        chk("t1_pre_tie", 32'(pif.tie_flag), 32'd1);
        chk("t1_pre_en", 32'(ro_en), 32'd1);
        rst_n = 1'b1;
        cyc(1);
        chk("t1_rst1", 32'({ro_sel, ro_en, pif.busy, pif.resp_valid, pif.tie_flag, pif.sat_flag}), 32'd0);
        chk("t1_rst1_resp", 32'(pif.resp), 32'd0);
        cyc(2);
        rst_n = 1'b0;
        cyc(1);
        chk("t1_after", 32'({ro_sel, ro_en, pif.busy, pif.resp_valid}), 32'd0);

        // odd selects only: alternating response with ties
        run_seq(4'h0, 1'b0);
        chk("t3_resp", 32'(pif.resp), 32'hAA);
        chk("t3_tie", 32'(pif.tie_flag), 32'd1);
        chk("t3_sat", 32'(pif.sat_flag), 32'd0);
        ack();

        // saturation on the narrow-counter instance
        pif3.challenge = 4'h0;
        pif3.start     = 1'b1;
        cyc(1);
        pif3.start = 1'b0;
        chk("t5_busy", 32'(pif3.busy), 32'd1);
        cyc(167);
        chk("t5_valid_early", 32'(pif3.resp_valid), 32'd0);
        cyc(1);
        chk("t5_valid", 32'(pif3.resp_valid), 32'd1);
        chk("t5_resp", 32'(pif3.resp), 32'hFF);
        chk("t5_sat", 32'(pif3.sat_flag), 32'd1);
        chk("t5_tie", 32'(pif3.tie_flag), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
